ex_stall_ctrl: RTL and testbench

Execute-stage sequencing controller for the RF_EX pipeline register.
- Holds RF_EX (drives its stall input) while the multi-cycle multiplier occupies EX.
- Runs the data-memory request/ack handshake for the address lane.
- Handles pipeline flush, including a memory request still in flight.
- Produces single-cycle writeback-valid pulses for the mult and load lanes.

---
 rtl/ex_stall_ctrl.sv | 102 ++++++++++
 tb/tb_ex_stall_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/ex_stall_ctrl.sv
// Execute-stage sequencing for RF_EX: multi-cycle mult hold, data-memory
// handshake with flush/orphan handling, and one-shot writeback-valid pulses.
module ex_stall_ctrl #(
  parameter int MULT_LAT    = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ex_mult_vld,
  input  logic ex_mem_vld,
  input  logic ex_mem_rd,
  input  logic mem_ack,
  input  logic flush,
  output logic stall_rf_ex,
  output logic kill_rf_ex,
  output logic mem_req,
  output logic mult_wb_vld,
  output logic ld_wb_vld,
  output logic mem_err
);
  typedef enum logic [1:0] {M_IDLE, M_WAIT, M_DONE} mstate_e;

  mstate_e    state;
  logic [3:0] mult_cnt;
  logic [4:0] to_cnt;
  logic       drop, mult_done_r, rd_r;
  logic       mult_last, stall_mult, stall_mem, wait_drop;

  assign mult_last   = (mult_cnt == 4'(MULT_LAT-1));
  assign stall_mult  = ex_mult_vld & ~mult_last & ~mult_done_r;
  assign mult_wb_vld = ex_mult_vld & mult_last & ~mult_done_r & ~flush;
  // orphaned request: hold regardless of flush until its ack drains
  assign wait_drop   = (state == M_WAIT) & drop;
  assign stall_mem   = (~mem_err & ex_mem_vld & (state != M_DONE)) | wait_drop;
  assign stall_rf_ex = ((stall_mult | stall_mem) & ~flush) | wait_drop;
  assign kill_rf_ex  = flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_cnt    <= '0;
      mult_done_r <= 1'b0;
    end else begin
      if (flush | mult_last)
        mult_cnt <= '0;
      else if (ex_mult_vld & ~mult_done_r)
        mult_cnt <= mult_cnt + 4'd1;
      // remembers an already-written-back mult while EX is held by the mem lane
      if (flush | ~stall_rf_ex)
        mult_done_r <= 1'b0;
      else if (mult_wb_vld)
        mult_done_r <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= M_IDLE;
      to_cnt    <= '0;
      drop      <= 1'b0;
      rd_r      <= 1'b0;
      mem_req   <= 1'b0;
      ld_wb_vld <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      ld_wb_vld <= 1'b0;
      case (state)
        M_IDLE: begin
          if (ex_mem_vld & ~flush & ~mem_err) begin
            state   <= M_WAIT;
            mem_req <= 1'b1;
            rd_r    <= ex_mem_rd;
            to_cnt  <= '0;
          end
        end
        M_WAIT: begin
          if (flush) drop <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            drop    <= 1'b0;
            if (drop | flush) begin
              state <= M_IDLE;
            end else begin
              state     <= M_DONE;
              ld_wb_vld <= rd_r;
            end
          end else if (to_cnt == 5'(MEM_TIMEOUT-1)) begin
            mem_req <= 1'b0;
            mem_err <= 1'b1;
            drop    <= 1'b0;
            state   <= M_IDLE;
          end else begin
            to_cnt <= to_cnt + 5'd1;
          end
        end
        M_DONE: begin
          if (flush | ~stall_rf_ex) state <= M_IDLE;
        end
        default: state <= M_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_stall_ctrl.sv
// Directed bench for ex_stall_ctrl: per-cycle expected output vectors
// {stall, kill, req, mult_wb, ld_wb, err}, checked mid-cycle.
module tb_ex_stall_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ex_mult_vld = 0, ex_mem_vld = 0, ex_mem_rd = 0, mem_ack = 0, flush = 0;
  logic stall_rf_ex, kill_rf_ex, mem_req, mult_wb_vld, ld_wb_vld, mem_err;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  ex_stall_ctrl #(.MULT_LAT(3), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .ex_mult_vld(ex_mult_vld), .ex_mem_vld(ex_mem_vld),
    .ex_mem_rd(ex_mem_rd), .mem_ack(mem_ack), .flush(flush),
    .stall_rf_ex(stall_rf_ex), .kill_rf_ex(kill_rf_ex), .mem_req(mem_req),
    .mult_wb_vld(mult_wb_vld), .ld_wb_vld(ld_wb_vld), .mem_err(mem_err));

  function automatic logic [5:0] obs();
    return {stall_rf_ex, kill_rf_ex, mem_req, mult_wb_vld, ld_wb_vld, mem_err};
  endfunction

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] o;
    o = obs();
    checks++;
    assert (o === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, o, exp);
    end
  endtask

  // one cycle: drive inputs after the edge, check mid-cycle, advance
  task automatic cyc(input string tag, input logic mv, memv, rd, ack, fl,
                     input logic [5:0] exp);
    ex_mult_vld = mv; ex_mem_vld = memv; ex_mem_rd = rd; mem_ack = ack; flush = fl;
    @(negedge clk);
    chk(tag, exp);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ex_mult_vld = 0; ex_mem_vld = 0; ex_mem_rd = 0; mem_ack = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    @(negedge clk); chk("reset", 6'b000000);
    @(posedge clk); #1;

    // mult, 3-cycle occupancy
    cyc("mult_c0", 1,0,0,0,0, 6'b100000);
    cyc("mult_c1", 1,0,0,0,0, 6'b100000);
    cyc("mult_c2", 1,0,0,0,0, 6'b000100);
    cyc("mult_c3", 0,0,0,0,0, 6'b000000);

    // load, ack at cycle 4
    cyc("ld_c0", 0,1,1,0,0, 6'b100000);
    for (int i = 1; i < 4; i++) cyc("ld_wait", 0,1,1,0,0, 6'b101000);
    cyc("ld_c4ack", 0,1,1,1,0, 6'b101000);
    cyc("ld_c5", 0,1,1,0,0, 6'b000010);
    cyc("ld_c6", 0,0,0,0,0, 6'b000000);

    // store, same timing, no writeback pulse
    cyc("st_c0", 0,1,0,0,0, 6'b100000);
    for (int i = 1; i < 4; i++) cyc("st_wait", 0,1,0,0,0, 6'b101000);
    cyc("st_c4ack", 0,1,0,1,0, 6'b101000);
    cyc("st_c5", 0,1,0,0,0, 6'b000000);
    cyc("st_c6", 0,0,0,0,0, 6'b000000);

    // mult + load together, ack at cycle 5
    cyc("ml_c0", 1,1,1,0,0, 6'b100000);
    cyc("ml_c1", 1,1,1,0,0, 6'b101000);
    cyc("ml_c2", 1,1,1,0,0, 6'b101100);
    cyc("ml_c3", 1,1,1,0,0, 6'b101000);
    cyc("ml_c4", 1,1,1,0,0, 6'b101000);
    cyc("ml_c5ack", 1,1,1,1,0, 6'b101000);
    cyc("ml_c6", 1,1,1,0,0, 6'b000010);
    cyc("ml_c7", 0,0,0,0,0, 6'b000000);

    // flush with request in flight; orphaned ack at cycle 6
    cyc("fl_c0", 0,1,1,0,0, 6'b100000);
    cyc("fl_c1", 0,1,1,0,0, 6'b101000);
    cyc("fl_c2", 0,1,1,0,1, 6'b011000);
    for (int i = 3; i < 6; i++) cyc("fl_hold", 0,0,0,0,0, 6'b101000);
    cyc("fl_c6ack", 0,0,0,1,0, 6'b101000);
    cyc("fl_c7", 0,0,0,0,0, 6'b000000);
    cyc("fl_c8", 0,0,0,0,0, 6'b000000);

    // flush in idle: no request issued
    cyc("fli_c0", 0,1,1,0,1, 6'b010000);
    cyc("fli_c1", 0,0,0,0,0, 6'b000000);

    // timeout: no ack for 16 wait cycles
    cyc("to_c0", 0,1,1,0,0, 6'b100000);
    for (int i = 1; i <= 16; i++) cyc("to_wait", 0,1,1,0,0, 6'b101000);
    cyc("to_c17", 0,1,1,0,0, 6'b000001);
    cyc("to_c18", 0,1,1,0,0, 6'b000001);
    cyc("to_c19ack", 0,1,1,1,0, 6'b000001);
    cyc("to_after", 0,0,0,0,0, 6'b000001);

    // async reset mid-wait
    do_reset();
    @(negedge clk); chk("reset2", 6'b000000);
    @(posedge clk); #1;
    cyc("rs_c0", 0,1,1,0,0, 6'b100000);
    cyc("rs_c1", 0,1,1,0,0, 6'b101000);
    ex_mem_vld = 0; ex_mem_rd = 0;
    #2 rst_n = 1'b0;
    #1 chk("rs_async", 6'b000000);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc("rs_ack", 0,0,0,1,0, 6'b000000);
    cyc("rs_after", 0,0,0,0,0, 6'b000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
